ahb_write_slave_fifo: RTL and testbench

Parametrised AHB-Lite write slave for the system DMA path, the successor to the fixed 32-bit write slave. It decodes its own address window, generates byte strobes from HSIZE/HADDR, and buffers accepted write beats in a DEPTH-entry FIFO drained by a valid/ready memory port. It inserts wait states when the FIFO is full, returns a two-cycle ERROR for illegal transfers, and reports burst completion and beat counts.

---
 rtl/ahb_write_slave_fifo.sv | 177 +++++++++++++++++
 tb/tb_ahb_write_slave_fifo.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_write_slave_fifo.sv
// AHB-Lite write slave with address-window decode, byte-strobe generation and a
// DEPTH-entry write FIFO drained through a valid/ready memory port.
module ahb_write_slave_fifo #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DEPTH     = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       ADDR_SPAN = 4096
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic                     HSEL,
  input  logic [ADDR_W-1:0]        HADDR,
  input  logic [DATA_W-1:0]        HWDATA,
  input  logic                     HWRITE,
  input  logic [2:0]               HBURST,
  input  logic [2:0]               HSIZE,
  input  logic [1:0]               HTRANS,
  input  logic                     HREADY,
  output logic                     HREADYOUT,
  output logic                     HRESP,
  output logic                     mem_wr_valid,
  input  logic                     mem_wr_ready,
  output logic [ADDR_W-1:0]        mem_wr_addr,
  output logic [DATA_W-1:0]        mem_wr_data,
  output logic [DATA_W/8-1:0]      mem_wr_strb,
  output logic                     slave_done,
  output logic [7:0]               beat_count,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int unsigned       StrbW   = DATA_W / 8;
  localparam int unsigned       LaneW   = $clog2(StrbW);
  localparam int unsigned       PtrW    = $clog2(DEPTH);
  localparam int unsigned       LvlW    = PtrW + 1;
  localparam logic [ADDR_W-1:0] OfsMask = ADDR_W'(ADDR_SPAN - 1);
  localparam logic [1:0]        TransIdle   = 2'b00;
  localparam logic [1:0]        TransNonseq = 2'b10;
  localparam logic [1:0]        TransSeq    = 2'b11;

  typedef enum logic [1:0] {StIdle, StData, StErr1, StErr2} state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [StrbW-1:0]      strb_q, strb_d;
  logic                  seq_q, seq_d;
  logic                  burst_q, burst_d;
  logic                  done_q, done_d;
  logic [7:0]            beat_q, beat_d;
  logic [LvlW-1:0]       level_q, level_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  logic [ADDR_W-1:0]     fifo_addr [DEPTH];
  logic [DATA_W-1:0]     fifo_data [DEPTH];
  logic [StrbW-1:0]      fifo_strb [DEPTH];

  logic [LaneW-1:0]      lane;
  logic [7:0]            nbytes;
  logic [StrbW-1:0]      strb_calc;
  logic                  legal, addr_ph, ends_burst, push, pop, decode_en, burst_live;
  logic                  unused_hburst;

  assign unused_hburst = ^HBURST;

  always_comb begin
    lane   = HADDR[LaneW-1:0];
    nbytes = 8'd1 << HSIZE;
    for (int unsigned i = 0; i < StrbW; i++) begin
      strb_calc[i] = (i >= 32'(lane)) && (i < 32'(lane) + 32'(nbytes));
    end
    legal = HWRITE && ((HADDR & ~OfsMask) == BASE_ADDR) && (HSIZE <= 3'(LaneW)) &&
            ((HADDR[7:0] & (nbytes - 8'd1)) == 8'd0);
  end

  assign addr_ph    = HSEL && HTRANS[1];
  assign ends_burst = !HSEL || (HTRANS == TransIdle) || (HTRANS == TransNonseq);
  assign push       = (state_q == StData) && (level_q < LvlW'(DEPTH));
  assign pop        = (level_q != '0) && mem_wr_ready;
  assign burst_live = burst_q || push;
  // Address phases are only taken while the bus is ready and we are not mid data phase.
  assign decode_en  = HREADY && ((state_q == StIdle) || (state_q == StErr2) || push);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    strb_d   = strb_q;
    seq_d    = seq_q;
    burst_d  = burst_live;
    done_d   = 1'b0;
    beat_d   = beat_q;
    level_d  = level_q + LvlW'(push) - LvlW'(pop);
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);

    if (push) begin
      beat_d = !seq_q ? 8'd1 : (beat_q == 8'hFF) ? beat_q : beat_q + 8'd1;
    end

    if (state_q == StErr1) begin
      state_d = StErr2;
    end else if (decode_en) begin
      if (burst_live && ends_burst) begin
        done_d  = 1'b1;
        burst_d = 1'b0;
      end
      if (addr_ph && legal) begin
        state_d = StData;
        addr_d  = HADDR & OfsMask;
        strb_d  = strb_calc;
        seq_d   = (HTRANS == TransSeq);
      end else if (addr_ph) begin
        // An erroring transfer terminates any open burst silently.
        state_d = StErr1;
        done_d  = 1'b0;
        burst_d = 1'b0;
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      strb_q   <= '0;
      seq_q    <= 1'b0;
      burst_q  <= 1'b0;
      done_q   <= 1'b0;
      beat_q   <= '0;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      strb_q   <= strb_d;
      seq_q    <= seq_d;
      burst_q  <= burst_d;
      done_q   <= done_d;
      beat_q   <= beat_d;
      level_q  <= level_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (push) begin
      fifo_addr[wr_ptr_q] <= addr_q;
      fifo_data[wr_ptr_q] <= HWDATA;
      fifo_strb[wr_ptr_q] <= strb_q;
    end
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    unique case (state_q)
      StIdle:  HREADYOUT = 1'b1;
      StData:  HREADYOUT = (level_q < LvlW'(DEPTH));
      StErr1:  begin HREADYOUT = 1'b0; HRESP = 1'b1; end
      StErr2:  begin HREADYOUT = 1'b1; HRESP = 1'b1; end
      default: HREADYOUT = 1'b1;
    endcase
  end

  // Head fields are masked to zero when empty so the port reads clean after reset.
  assign mem_wr_valid = (level_q != '0);
  assign mem_wr_addr  = mem_wr_valid ? fifo_addr[rd_ptr_q] : '0;
  assign mem_wr_data  = mem_wr_valid ? fifo_data[rd_ptr_q] : '0;
  assign mem_wr_strb  = mem_wr_valid ? fifo_strb[rd_ptr_q] : '0;
  assign slave_done   = done_q;
  assign beat_count   = beat_q;
  assign fifo_level   = level_q;

endmodule

// File: tb/tb_ahb_write_slave_fifo.sv
// Directed bench for ahb_write_slave_fifo: single, INCR4 stall, strobes, errors,
// BUSY insertion and mid-burst reset.
module tb_ahb_write_slave_fifo;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned DP = 4;
  localparam logic [1:0] TI = 2'b00, TB = 2'b01, TN = 2'b10, TS = 2'b11;

  logic          HCLK, HRESET, HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
  logic [AW-1:0] HADDR;
  logic [DW-1:0] HWDATA;
  logic [2:0]    HBURST, HSIZE;
  logic [1:0]    HTRANS;
  logic          mem_wr_valid, mem_wr_ready, slave_done;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic [3:0]    mem_wr_strb;
  logic [7:0]    beat_count;
  logic [2:0]    fifo_level;

  int n_tests = 0;
  int n_fail  = 0;

  ahb_write_slave_fifo #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .BASE_ADDR(32'h0000_1000), .ADDR_SPAN(4096)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
    .HWRITE(HWRITE), .HBURST(HBURST), .HSIZE(HSIZE), .HTRANS(HTRANS), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .mem_wr_valid(mem_wr_valid),
    .mem_wr_ready(mem_wr_ready), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_strb(mem_wr_strb), .slave_done(slave_done), .beat_count(beat_count),
    .fifo_level(fifo_level)
  );

  assign HREADY = HREADYOUT;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic addr_phase(input logic w, input logic [AW-1:0] a, input logic [2:0] sz,
                            input logic [1:0] tr, input logic [2:0] bu);
    HSEL = 1'b1; HWRITE = w; HADDR = a; HSIZE = sz; HTRANS = tr; HBURST = bu;
  endtask

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = TI; HWRITE = 1'b0; HBURST = 3'd0;
  endtask

  task automatic err_seq(input string tag, input logic w, input logic [AW-1:0] a,
                         input logic [2:0] sz);
    addr_phase(w, a, sz, TN, 3'd0);
    tick();
    check({tag, "_err1_rdy"}, HREADYOUT, 0);
    check({tag, "_err1_resp"}, HRESP, 1);
    check({tag, "_err1_done"}, slave_done, 0);
    bus_idle();
    tick();
    check({tag, "_err2_rdy"}, HREADYOUT, 1);
    check({tag, "_err2_resp"}, HRESP, 1);
    check({tag, "_err2_lvl"}, fifo_level, 0);
    tick();
    check({tag, "_post_resp"}, HRESP, 0);
    check({tag, "_post_valid"}, mem_wr_valid, 0);
    check({tag, "_post_done"}, slave_done, 0);
  endtask

  initial begin
    logic [1:0] tr [11];
    int dones, pops, bidx;

    HRESET = 1'b1; HSEL = 0; HADDR = 0; HWDATA = 0; HWRITE = 0; HBURST = 0; HSIZE = 0;
    HTRANS = TI; mem_wr_ready = 0;
    tick(); tick();
    check("rst_hreadyout", HREADYOUT, 1);
    check("rst_hresp", HRESP, 0);
    check("rst_valid", mem_wr_valid, 0);
    check("rst_addr", mem_wr_addr, 0);
    check("rst_data", mem_wr_data, 0);
    check("rst_strb", mem_wr_strb, 0);
    check("rst_done", slave_done, 0);
    check("rst_beat", beat_count, 0);
    check("rst_level", fifo_level, 0);
    HRESET = 1'b0;
    tick();

    // Single word write
    mem_wr_ready = 1;
    addr_phase(1, 32'h1010, 3'd2, TN, 3'd0);
    tick();
    check("single_rdy", HREADYOUT, 1);
    check("single_resp", HRESP, 0);
    bus_idle(); HWDATA = 32'hDEAD_BEEF;
    tick();
    check("single_valid", mem_wr_valid, 1);
    check("single_addr", mem_wr_addr, 32'h10);
    check("single_data", mem_wr_data, 32'hDEAD_BEEF);
    check("single_strb", mem_wr_strb, 4'hF);
    check("single_done", slave_done, 1);
    check("single_beat", beat_count, 1);
    tick();
    check("single_drain", mem_wr_valid, 0);
    check("single_done_1cyc", slave_done, 0);

    // INCR4 into a blocked memory, then a stalled NONSEQ
    mem_wr_ready = 0;
    addr_phase(1, 32'h1000, 3'd2, TN, 3'd3);
    tick();
    for (int i = 1; i < 4; i++) begin
      addr_phase(1, 32'h1000 + 32'(4 * i), 3'd2, TS, 3'd3);
      HWDATA = 32'hA0 + 32'(i - 1);
      tick();
    end
    addr_phase(1, 32'h1020, 3'd2, TN, 3'd0);
    HWDATA = 32'hA3;
    tick();
    check("incr4_level", fifo_level, 4);
    check("incr4_beat", beat_count, 4);
    check("incr4_done", slave_done, 1);
    check("incr4_full_rdy", HREADYOUT, 0);
    bus_idle(); HWDATA = 32'hB4;
    tick();
    check("stall_rdy", HREADYOUT, 0);
    check("stall_level", fifo_level, 4);
    check("stall_done", slave_done, 0);
    check("head0_addr", mem_wr_addr, 32'h0);
    check("head0_data", mem_wr_data, 32'hA0);
    tick();
    check("stall2_rdy", HREADYOUT, 0);
    mem_wr_ready = 1;
    tick();
    check("release_rdy", HREADYOUT, 1);
    check("release_level", fifo_level, 3);
    check("head1_data", mem_wr_data, 32'hA1);
    tick();
    check("pushpop_level", fifo_level, 3);
    check("head2_data", mem_wr_data, 32'hA2);
    check("nonseq_done", slave_done, 1);
    check("nonseq_beat", beat_count, 1);
    tick();
    check("head3_data", mem_wr_data, 32'hA3);
    check("head3_addr", mem_wr_addr, 32'hC);
    tick();
    check("head4_data", mem_wr_data, 32'hB4);
    check("head4_addr", mem_wr_addr, 32'h20);
    tick();
    check("incr4_empty", mem_wr_valid, 0);

    // Byte strobe, then illegal transfers
    addr_phase(1, 32'h1003, 3'd0, TN, 3'd0);
    tick();
    bus_idle(); HWDATA = 32'h1122_3344;
    tick();
    check("byte_valid", mem_wr_valid, 1);
    check("byte_strb", mem_wr_strb, 4'h8);
    check("byte_addr", mem_wr_addr, 32'h3);
    tick();
    err_seq("half_misalign", 1, 32'h1001, 3'd1);
    err_seq("read", 0, 32'h1000, 3'd2);
    err_seq("out_of_window", 1, 32'h2000, 3'd2);

    // INCR8 with two BUSY cycles after the third beat
    tr = '{TN, TS, TS, TB, TB, TS, TS, TS, TS, TS, TI};
    dones = 0; pops = 0; bidx = 0;
    for (int i = 0; i < 11; i++) begin
      HSEL = 1; HWRITE = 1; HSIZE = 3'd2; HBURST = 3'd5; HTRANS = tr[i];
      HADDR = 32'h1100 + 32'(4 * bidx);
      if (tr[i][1]) bidx++;
      HWDATA = 32'hC0 + 32'(i);
      check("busy_burst_okay", {HREADYOUT, HRESP}, 2'b10);
      tick();
      dones += int'(slave_done);
      pops  += int'(mem_wr_valid);
    end
    bus_idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      dones += int'(slave_done);
      pops  += int'(mem_wr_valid);
    end
    check("incr8_beat", beat_count, 8);
    check("incr8_dones", dones, 1);
    check("incr8_pushes", pops, 8);

    // Reset in the middle of an INCR4
    mem_wr_ready = 0;
    addr_phase(1, 32'h1000, 3'd2, TN, 3'd3);
    tick();
    for (int i = 1; i < 4; i++) begin
      addr_phase(1, 32'h1000 + 32'(4 * i), 3'd2, TS, 3'd3);
      HWDATA = 32'hE0 + 32'(i);
      tick();
    end
    check("pre_rst_level", fifo_level, 3);
    #2 HRESET = 1'b1;
    #1;
    check("async_rst_level", fifo_level, 0);
    check("async_rst_valid", mem_wr_valid, 0);
    check("async_rst_rdy", HREADYOUT, 1);
    bus_idle();
    tick();
    HRESET = 1'b0;
    mem_wr_ready = 1;
    addr_phase(1, 32'h1040, 3'd2, TN, 3'd0);
    tick();
    check("post_rst_rdy", HREADYOUT, 1);
    bus_idle(); HWDATA = 32'h5A5A_5A5A;
    tick();
    check("post_rst_valid", mem_wr_valid, 1);
    check("post_rst_addr", mem_wr_addr, 32'h40);
    check("post_rst_data", mem_wr_data, 32'h5A5A_5A5A);
    check("post_rst_beat", beat_count, 1);
    check("post_rst_done", slave_done, 1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
